// File: rtl/uart_mem_pkg.sv
// Shared definitions for the RAM-to-UART byte reader: default widths,
// controller state encoding and byte-lane extraction.
package uart_mem_pkg;

    localparam int DEF_ADDR_W = 13;
    localparam int DEF_LEN_W  = 16;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DRAIN,
        DONE
    } state_t;

    // Little-endian lane pick: lane 0 is the least significant byte.
    function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_mem_byte_reader_if.sv
// Bundle of command/status, Avalon-MM read master and byte-stream signals.
// master = reader side, slave = environment (command source, RAM, UART TX).
interface uart_mem_byte_reader_if #(
    parameter int ADDR_W = 13,
    parameter int LEN_W  = 16
);
    logic              cmd_start;
    logic [ADDR_W-1:0] cmd_base;
    logic [LEN_W-1:0]  cmd_len;
    logic              cmd_abort;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] m_address;
    logic              m_chipselect;
    logic              m_write;
    logic [3:0]        m_byteenable;
    logic              m_clken;
    logic [31:0]       m_readdata;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (
        input  cmd_start, cmd_base, cmd_len, cmd_abort, m_readdata, tx_ready,
        output busy, done, m_address, m_chipselect, m_write, m_byteenable, m_clken,
               tx_data, tx_valid
    );

    modport slave (
        output cmd_start, cmd_base, cmd_len, cmd_abort, m_readdata, tx_ready,
        input  busy, done, m_address, m_chipselect, m_write, m_byteenable, m_clken,
               tx_data, tx_valid
    );

endinterface

// File: rtl/uart_word_unpacker.sv
// One-word buffer that walks its four bytes out over a valid/ready stream,
// least significant byte first.
module uart_word_unpacker
    import uart_mem_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic [31:0] load_data,
    input  logic        present,
    input  logic        freeze,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        fire,
    output logic        lane_last
);

    logic [31:0] word_buf;
    logic [1:0]  lane;

    // A fresh word always restarts at lane 0, so partial words and aborts
    // never leave a stale lane behind.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            word_buf <= '0;
            lane     <= '0;
        end else if (load) begin
            word_buf <= load_data;
            lane     <= '0;
        end else if (fire) begin
            lane <= lane + 2'd1;
        end
    end

    assign tx_valid  = present;
    assign tx_data   = present ? lane_byte(word_buf, lane) : 8'h00;
    assign fire      = present & tx_ready & ~freeze;
    assign lane_last = (lane == 2'd3);

endmodule

// File: rtl/uart_mem_byte_reader.sv
// Avalon-MM read master that streams a byte range of the on-chip RAM to the
// UART TX path, one word in flight at a time.
module uart_mem_byte_reader
    import uart_mem_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int LEN_W        = DEF_LEN_W,
    parameter int READ_LATENCY = 1
) (
    input  logic clk,
    input  logic reset_n,
    uart_mem_byte_reader_if.master bus
);

    localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY - 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0]  remaining;
    logic [1:0]        lat_cnt;
    logic              word_load;
    logic              fire;
    logic              lane_last;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            lat_cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && bus.cmd_start) begin
                cur_addr  <= bus.cmd_base;
                remaining <= bus.cmd_len;
            end else if (fire) begin
                remaining <= remaining - 1'b1;
                if (lane_last)
                    cur_addr <= cur_addr + 1'b1;
            end
            lat_cnt <= (state == WAIT) ? lat_cnt + 2'd1 : 2'd0;
        end
    end

    // Abort overrides everything outside IDLE, including a capture or handshake.
    always_comb begin
        state_nxt = state;
        word_load = (state == WAIT) && (lat_cnt == LAT_LAST) && !bus.cmd_abort;
        case (state)
            IDLE: begin
                if (bus.cmd_start)
                    state_nxt = (bus.cmd_len == '0) ? DONE : ISSUE;
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (lat_cnt == LAT_LAST)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (fire) begin
                    if (remaining == LEN_W'(1))
                        state_nxt = DONE;
                    else if (lane_last)
                        state_nxt = ISSUE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (state != IDLE && bus.cmd_abort)
            state_nxt = IDLE;
    end

    assign bus.busy         = (state != IDLE);
    assign bus.done         = (state == DONE);
    assign bus.m_chipselect = (state == ISSUE);
    assign bus.m_address    = (state == ISSUE) ? cur_addr : '0;
    assign bus.m_write      = 1'b0;
    assign bus.m_byteenable = 4'hF;
    assign bus.m_clken      = 1'b1;

    uart_word_unpacker u_unpacker (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (word_load),
        .load_data (bus.m_readdata),
        .present   (state == DRAIN),
        .freeze    (bus.cmd_abort),
        .tx_ready  (bus.tx_ready),
        .tx_data   (bus.tx_data),
        .tx_valid  (bus.tx_valid),
        .fire      (fire),
        .lane_last (lane_last)
    );

endmodule

// File: tb/tb_uart_mem_byte_reader.sv
// Directed bench: two readers (read latency 1 and 2) share one command source;
// each has its own RAM model holding word[n] = {n+3,n+2,n+1,n}.
module tb_uart_mem_byte_reader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_start;
    logic [12:0] cmd_base;
    logic [15:0] cmd_len;
    logic        cmd_abort;
    logic        tx_ready;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_mem_byte_reader_if #(.ADDR_W(13), .LEN_W(16)) bus1 ();
    uart_mem_byte_reader_if #(.ADDR_W(13), .LEN_W(16)) bus2 ();

    assign bus1.cmd_start = cmd_start;
    assign bus1.cmd_base  = cmd_base;
    assign bus1.cmd_len   = cmd_len;
    assign bus1.cmd_abort = cmd_abort;
    assign bus1.tx_ready  = tx_ready;
    assign bus2.cmd_start = cmd_start;
    assign bus2.cmd_base  = cmd_base;
    assign bus2.cmd_len   = cmd_len;
    assign bus2.cmd_abort = cmd_abort;
    assign bus2.tx_ready  = tx_ready;

    uart_mem_byte_reader #(.ADDR_W(13), .LEN_W(16), .READ_LATENCY(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1.master)
    );
    uart_mem_byte_reader #(.ADDR_W(13), .LEN_W(16), .READ_LATENCY(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .bus(bus2.master)
    );

    function automatic logic [31:0] word_of(input logic [12:0] a);
        logic [7:0] b;
        b = a[7:0];
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    // RAM models: garbage when no read was issued, so a wrong capture shows up.
    logic [31:0] ram1_q, ram2_a, ram2_b;
    always @(posedge clk) begin
        ram1_q <= bus1.m_chipselect ? word_of(bus1.m_address) : 32'hA5A5_A5A5;
        ram2_a <= bus2.m_chipselect ? word_of(bus2.m_address) : 32'hA5A5_A5A5;
        ram2_b <= ram2_a;
    end
    assign bus1.m_readdata = ram1_q;
    assign bus2.m_readdata = ram2_b;

    logic [31:0] bytes1[$], bytes2[$], addrs1[$], addrs2[$];
    int          done1, done2, valid1, valid2, cs1, stall_err, write_seen;
    logic        stall_prev;
    logic [7:0]  stall_data;

    always @(negedge clk) begin
        if (bus1.tx_valid && tx_ready) bytes1.push_back(32'(bus1.tx_data));
        if (bus2.tx_valid && tx_ready) bytes2.push_back(32'(bus2.tx_data));
        if (bus1.m_chipselect) begin addrs1.push_back(32'(bus1.m_address)); cs1++; end
        if (bus2.m_chipselect) addrs2.push_back(32'(bus2.m_address));
        if (bus1.done) done1++;
        if (bus2.done) done2++;
        if (bus1.tx_valid) valid1++;
        if (bus2.tx_valid) valid2++;
        if (bus1.m_write || bus2.m_write) write_seen++;
        if (stall_prev && (!bus1.tx_valid || bus1.tx_data !== stall_data)) stall_err++;
        stall_prev = bus1.tx_valid && !tx_ready;
        stall_data = bus1.tx_data;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic checkSeq(input string tag, input logic [31:0] got[$], input logic [31:0] exp[$]);
        checkOutput({tag, "_count"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++)
            checkOutput($sformatf("%s_%0d", tag, i),
                        (i < got.size()) ? got[i] : 32'hFFFF_FFFF, exp[i]);
    endtask

    task automatic clearMon();
        bytes1.delete(); bytes2.delete(); addrs1.delete(); addrs2.delete();
        done1 = 0; done2 = 0; valid1 = 0; valid2 = 0; cs1 = 0;
        stall_err = 0; stall_prev = 1'b0;
    endtask

    task automatic applyStimulus(input logic [12:0] base, input logic [15:0] len);
        @(posedge clk); #1;
        clearMon();
        cmd_base  = base;
        cmd_len   = len;
        cmd_start = 1'b1;
        @(posedge clk); #1;
        cmd_start = 1'b0;
    endtask

    task automatic waitIdle(input int budget, input bit toggle);
        int n = 0;
        while ((bus1.busy || bus2.busy) && n < budget) begin
            @(posedge clk); #1;
            if (toggle) tx_ready = ~tx_ready;
            n++;
        end
        tx_ready = 1'b1;
        checkOutput("idle_reached", {30'b0, bus1.busy, bus2.busy}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_busy"},  32'(bus1.busy), 32'h0);
        checkOutput({tag, "_done"},  32'(bus1.done), 32'h0);
        checkOutput({tag, "_cs"},    32'(bus1.m_chipselect), 32'h0);
        checkOutput({tag, "_addr"},  32'(bus1.m_address), 32'h0);
        checkOutput({tag, "_valid"}, 32'(bus1.tx_valid), 32'h0);
        checkOutput({tag, "_data"},  32'(bus1.tx_data), 32'h0);
        checkOutput({tag, "_busy2"}, 32'(bus2.busy), 32'h0);
    endtask

    logic [31:0] exp_q[$];

    initial begin
        reset_n = 1'b0; cmd_start = 1'b0; cmd_base = '0; cmd_len = '0;
        cmd_abort = 1'b0; tx_ready = 1'b1; write_seen = 0;
        clearMon();
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        checkResetValues("reset");
        checkOutput("reset_be",    32'(bus1.m_byteenable), 32'hF);
        checkOutput("reset_clken", 32'(bus1.m_clken), 32'h1);

        // Two full words, latency 1 and latency 2 in parallel.
        applyStimulus(13'd0, 16'd8);
        waitIdle(200, 1'b0);
        exp_q = '{32'h00, 32'h01, 32'h02, 32'h03, 32'h01, 32'h02, 32'h03, 32'h04};
        checkSeq("s1_bytes", bytes1, exp_q);
        checkSeq("s1_bytes_lat2", bytes2, exp_q);
        exp_q = '{32'd0, 32'd1};
        checkSeq("s1_addr", addrs1, exp_q);
        checkSeq("s1_addr_lat2", addrs2, exp_q);
        checkOutput("s1_done", 32'(done1), 32'd1);
        checkOutput("s1_done_lat2", 32'(done2), 32'd1);

        // Partial last word with a stalling consumer.
        applyStimulus(13'd5, 16'd6);
        waitIdle(300, 1'b1);
        exp_q = '{32'h05, 32'h06, 32'h07, 32'h08, 32'h06, 32'h07};
        checkSeq("s2_bytes", bytes1, exp_q);
        exp_q = '{32'd5, 32'd6};
        checkSeq("s2_addr", addrs1, exp_q);
        checkOutput("s2_stall_stable", 32'(stall_err), 32'd0);
        checkOutput("s2_done", 32'(done1), 32'd1);

        // Address wrap at the top of RAM, with a start pulse while busy.
        applyStimulus(13'd8191, 16'd8);
        @(posedge clk); #1;
        cmd_base = 13'd100; cmd_len = 16'd2; cmd_start = 1'b1;
        @(posedge clk); #1;
        cmd_start = 1'b0;
        waitIdle(200, 1'b0);
        exp_q = '{32'hFF, 32'h00, 32'h01, 32'h02, 32'h00, 32'h01, 32'h02, 32'h03};
        checkSeq("s3_bytes", bytes1, exp_q);
        exp_q = '{32'd8191, 32'd0};
        checkSeq("s3_addr", addrs1, exp_q);
        checkOutput("s3_done", 32'(done1), 32'd1);

        // Zero length: straight to DONE with no RAM or stream activity.
        applyStimulus(13'd7, 16'd0);
        checkOutput("s4_done_pulse", 32'(bus1.done), 32'h1);
        checkOutput("s4_busy_in_done", 32'(bus1.busy), 32'h1);
        @(posedge clk); #1;
        checkOutput("s4_done_low", 32'(bus1.done), 32'h0);
        checkOutput("s4_busy_low", 32'(bus1.busy), 32'h0);
        @(posedge clk); #1;
        checkOutput("s4_no_cs", 32'(cs1), 32'd0);
        checkOutput("s4_no_valid", 32'(valid1), 32'd0);
        checkOutput("s4_done_count", 32'(done1), 32'd1);

        // Abort after three bytes, then a clean follow-up transfer.
        applyStimulus(13'd0, 16'd12);
        begin
            int n = 0;
            while (bytes1.size() < 3 && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
        end
        checkOutput("s5_three_bytes", 32'(bytes1.size()), 32'd3);
        tx_ready  = 1'b0;
        cmd_abort = 1'b1;
        @(posedge clk); #1;
        cmd_abort = 1'b0;
        checkOutput("s5_valid_after_abort", 32'(bus1.tx_valid), 32'h0);
        checkOutput("s5_busy_after_abort", 32'(bus1.busy), 32'h0);
        tx_ready = 1'b1;
        waitIdle(100, 1'b0);
        checkOutput("s5_no_done", 32'(done1), 32'd0);
        exp_q = '{32'h00, 32'h01, 32'h02};
        checkSeq("s5_bytes", bytes1, exp_q);
        applyStimulus(13'd2, 16'd4);
        waitIdle(200, 1'b0);
        exp_q = '{32'h02, 32'h03, 32'h04, 32'h05};
        checkSeq("s5_restart_bytes", bytes1, exp_q);
        checkOutput("s5_restart_done", 32'(done1), 32'd1);

        // Reset while the first read is in flight.
        applyStimulus(13'd0, 16'd4);
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        clearMon();
        checkResetValues("s6");
        repeat (5) @(posedge clk);
        #1;
        checkOutput("s6_no_valid", 32'(valid1), 32'd0);
        checkOutput("s6_no_valid_lat2", 32'(valid2), 32'd0);
        checkOutput("s6_no_done", 32'(done1 + done2), 32'd0);

        checkOutput("never_write", 32'(write_seen), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
